radix2_divider: RTL and testbench

- Multi-cycle 32-bit integer divider. It is the responder side of the EXE-stage divide request: EXE issues the operands and waits; this block computes and hands back the result.
- Supports signed and unsigned operation, returning quotient and remainder together.
- Uses a fixed-latency restoring algorithm with valid/ready handshakes on both request and result sides.
- Accepts a pipeline flush (exception/ertn cancel) at any time.

---
 rtl/radix2_divider_pkg.sv | 6 +
 rtl/radix2_divider_if.sv | 22 ++
 rtl/radix2_divider_div_step.sv | 15 +
 rtl/radix2_divider.sv | 96 +++++++++
 tb/tb_radix2_divider.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/radix2_divider_pkg.sv
// radix2_divider_pkg: shared state encoding and widths for the radix-2 divider
package radix2_divider_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int CNT_W = $clog2(DIV_WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
endpackage

// File: rtl/radix2_divider_if.sv
// radix2_divider_if: EXE-stage divide request/result handshake bundle
interface radix2_divider_if #(parameter int WIDTH = radix2_divider_pkg::DIV_WIDTH);
  logic             div_valid;
  logic             div_ready;
  logic             div_signed;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             div_cancel;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic             div_busy;
  modport master (
    output div_valid, div_signed, x, y, div_cancel, res_ready,
    input  div_ready, res_valid, s, r, div_busy
  );
  modport slave (
    input  div_valid, div_signed, x, y, div_cancel, res_ready,
    output div_ready, res_valid, s, r, div_busy
  );
endinterface

// File: rtl/radix2_divider_div_step.sv
// div_step: one restoring iteration, shifts a dividend bit into the partial remainder and trial-subtracts
module div_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);
  logic [WIDTH:0] part, diff;
  assign part  = {rem_i, msb_i};
  // rem_i < divisor keeps part < 2*divisor, so the top diff bit is the borrow
  assign diff  = part - {1'b0, divisor_i};
  assign q_o   = ~diff[WIDTH];
  assign rem_o = q_o ? diff[WIDTH-1:0] : part[WIDTH-1:0];
endmodule

// File: rtl/radix2_divider.sv
// radix2_divider: fixed-latency restoring signed/unsigned divider with flush support
module radix2_divider
  import radix2_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic             clk,
  input logic             resetn,
  radix2_divider_if.slave div
);
  localparam int CW = $clog2(WIDTH);
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d, x_q, x_d, s_q, s_d, r_q, r_d;
  logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d, yz_q, yz_d;
  logic [WIDTH-1:0] step_rem, q_fin;
  logic             step_q;
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .msb_i     (dvd_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );
  // dvd_q shifts the dividend out at the top while quotient bits fill in at the bottom
  assign q_fin          = {dvd_q[WIDTH-2:0], step_q};
  assign div.div_ready  = state_q == IDLE;
  assign div.res_valid  = state_q == DONE;
  assign div.div_busy   = state_q != IDLE;
  assign div.s          = s_q;
  assign div.r          = r_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    x_d     = x_q;
    s_d     = s_q;
    r_d     = r_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    yz_d    = yz_q;
    if (div.div_cancel) begin
      state_d = IDLE;
    end else if (state_q == IDLE && div.div_valid) begin
      state_d = CALC;
      cnt_d   = '0;
      rem_d   = '0;
      dvd_d   = (div.div_signed && div.x[WIDTH-1]) ? -div.x : div.x;
      dvs_d   = (div.div_signed && div.y[WIDTH-1]) ? -div.y : div.y;
      q_neg_d = div.div_signed & (div.x[WIDTH-1] ^ div.y[WIDTH-1]);
      r_neg_d = div.div_signed & div.x[WIDTH-1];
      yz_d    = div.y == '0;
      x_d     = div.x;
    end else if (state_q == CALC) begin
      cnt_d = cnt_q + 1'b1;
      dvd_d = q_fin;
      rem_d = step_rem;
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = DONE;
        s_d     = yz_q ? '1 : q_neg_q ? -q_fin : q_fin;
        r_d     = yz_q ? x_q : r_neg_q ? -step_rem : step_rem;
      end
    end else if (state_q == DONE && div.res_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      x_q     <= '0;
      s_q     <= '0;
      r_q     <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      yz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      x_q     <= x_d;
      s_q     <= s_d;
      r_q     <= r_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      yz_q    <= yz_d;
    end
  end
endmodule

// File: tb/tb_radix2_divider.sv
// tb_radix2_divider: directed-vector bench for radix2_divider
module tb_radix2_divider;
  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   failures = 0;
  always #5 clk = ~clk;
  radix2_divider_if #(.WIDTH(32)) div_if ();
  radix2_divider dut (.clk(clk), .resetn(resetn), .div(div_if));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic start(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    div_if.div_valid  = 1'b1;
    div_if.div_signed = sgn;
    div_if.x          = a;
    div_if.y          = b;
    @(negedge clk);
    div_if.div_valid = 1'b0;
    div_if.x         = 32'hDEADBEEF;
    div_if.y         = 32'h0;
  endtask
  task automatic wait_res(output int lat, output logic rdy_seen);
    lat = 1;
    rdy_seen = 1'b0;
    while (!div_if.res_valid && lat < 100) begin
      rdy_seen |= div_if.div_ready;
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic take();
    div_if.res_ready = 1'b1;
    @(negedge clk);
    div_if.res_ready = 1'b0;
  endtask
  task automatic run(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] es, input logic [31:0] er);
    int   lat;
    logic rdy;
    start(sgn, a, b);
    wait_res(lat, rdy);
    check({tag, "_lat"}, lat, 33);
    check({tag, "_rdy_calc"}, {31'b0, rdy}, 0);
    check({tag, "_rdy_done"}, {31'b0, div_if.div_ready}, 0);
    check({tag, "_s"}, div_if.s, es);
    check({tag, "_r"}, div_if.r, er);
    take();
    check({tag, "_vld_after"}, {31'b0, div_if.res_valid}, 0);
    check({tag, "_rdy_after"}, {31'b0, div_if.div_ready}, 1);
  endtask
  initial begin
    int   lat;
    logic rdy, bad, seen;
    resetn            = 1'b0;
    div_if.div_valid  = 1'b0;
    div_if.div_signed = 1'b0;
    div_if.x          = '0;
    div_if.y          = '0;
    div_if.div_cancel = 1'b0;
    div_if.res_ready  = 1'b0;
    #12;
    check("rst_ready", {31'b0, div_if.div_ready}, 1);
    check("rst_valid", {31'b0, div_if.res_valid}, 0);
    check("rst_busy", {31'b0, div_if.div_busy}, 0);
    check("rst_s", div_if.s, 0);
    check("rst_r", div_if.r, 0);
    @(negedge clk);
    resetn = 1'b1;
    run("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    run("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
    run("u_m7_2", 1'b0, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1);
    run("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
    run("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0);
    run("s_dz", 1'b1, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678);
    run("u_dz", 1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678);
    run("s_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE);
    // result held under backpressure, then back-to-back request
    start(1'b0, 32'd1000, 32'd10);
    wait_res(lat, rdy);
    check("hold_lat", lat, 33);
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      bad |= !div_if.res_valid || div_if.div_ready || div_if.s !== 32'd100 || div_if.r !== 32'd0;
    end
    check("hold_stable", {31'b0, bad}, 0);
    div_if.res_ready  = 1'b1;
    div_if.div_valid  = 1'b1;
    div_if.div_signed = 1'b0;
    div_if.x          = 32'd50;
    div_if.y          = 32'd5;
    @(negedge clk);
    div_if.res_ready = 1'b0;
    check("b2b_vld", {31'b0, div_if.res_valid}, 0);
    check("b2b_rdy", {31'b0, div_if.div_ready}, 1);
    @(negedge clk);
    div_if.div_valid = 1'b0;
    check("b2b_busy", {31'b0, div_if.div_busy}, 1);
    wait_res(lat, rdy);
    check("b2b_lat", lat, 33);
    check("b2b_s", div_if.s, 32'd10);
    check("b2b_r", div_if.r, 32'd0);
    take();
    // cancel in CALC at counter 10
    start(1'b0, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    div_if.div_cancel = 1'b1;
    @(negedge clk);
    div_if.div_cancel = 1'b0;
    check("cxl_rdy", {31'b0, div_if.div_ready}, 1);
    check("cxl_busy", {31'b0, div_if.div_busy}, 0);
    seen = 1'b0;
    repeat (40) begin
      seen |= div_if.res_valid;
      @(negedge clk);
    end
    check("cxl_no_vld", {31'b0, seen}, 0);
    // cancel in DONE with res_ready
    start(1'b0, 32'd9, 32'd3);
    wait_res(lat, rdy);
    div_if.div_cancel = 1'b1;
    div_if.res_ready  = 1'b1;
    @(negedge clk);
    div_if.div_cancel = 1'b0;
    div_if.res_ready  = 1'b0;
    check("cxl_done_vld", {31'b0, div_if.res_valid}, 0);
    check("cxl_done_rdy", {31'b0, div_if.div_ready}, 1);
    // cancel in IDLE blocks acceptance
    @(negedge clk);
    div_if.div_valid  = 1'b1;
    div_if.div_cancel = 1'b1;
    div_if.x          = 32'd100;
    div_if.y          = 32'd7;
    @(negedge clk);
    div_if.div_valid  = 1'b0;
    div_if.div_cancel = 1'b0;
    check("idle_cxl_busy", {31'b0, div_if.div_busy}, 0);
    check("idle_cxl_rdy", {31'b0, div_if.div_ready}, 1);
    // asynchronous reset mid-CALC
    start(1'b1, 32'hFFFFFFF9, 32'd2);
    repeat (5) @(negedge clk);
    check("pre_rst_busy", {31'b0, div_if.div_busy}, 1);
    #1 resetn = 1'b0;
    #1;
    check("arst_ready", {31'b0, div_if.div_ready}, 1);
    check("arst_valid", {31'b0, div_if.res_valid}, 0);
    check("arst_busy", {31'b0, div_if.div_busy}, 0);
    check("arst_s", div_if.s, 0);
    check("arst_r", div_if.r, 0);
    @(negedge clk);
    resetn = 1'b1;
    run("post_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
